line_window_buffer: RTL and testbench

- Parametrised successor to the single-channel line buffer in the video pipeline.
- Stores the last BUF_DEPTH-1 active lines of a multi-channel pixel stream in a rotating bank of line RAMs.
- Each accepted pixel produces a vertically aligned column of BUF_DEPTH taps (current line plus previous lines) for downstream kernels: filters, edge detectors.
- Adds pixel-gated addressing, frame restart, line-count priming with optional top-border zero fill, and column-overflow detection.

---
 rtl/line_buffer_pkg.sv | 28 ++
 rtl/line_ram.sv | 33 +++
 rtl/line_window_buffer.sv | 145 ++++++++++++++
 tb/tb_line_window_buffer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg: constants and helpers shared by the line window buffer and the
// downstream kernels that consume its tap columns.
//   pix_width(): packed pixel width P = channels * color depth
//   tap_ram():   which line RAM holds tap k, i.e. (wr_line - k) mod num_rams
package line_buffer_pkg;

  // Default configuration of the video pipeline; kernels size themselves from these.
  localparam int unsigned DefColorDepth  = 8;
  localparam int unsigned DefChannels    = 3;
  localparam int unsigned DefScreenWidth = 1600;
  localparam int unsigned DefBufDepth    = 3;
  localparam int unsigned DefZeroFill    = 1;

  function automatic int unsigned pix_width(input int unsigned color_depth,
                                            input int unsigned channels);
    return color_depth * channels;
  endfunction

  // wr_line is always < num_rams, so one conditional add replaces a true modulo.
  function automatic int unsigned tap_ram(input int unsigned wr_line,
                                          input int unsigned k,
                                          input int unsigned num_rams);
    int unsigned kk;
    kk = k % num_rams;
    return (wr_line >= kk) ? (wr_line - kk) : (wr_line + num_rams - kk);
  endfunction

endpackage

// File: rtl/line_ram.sv
// line_ram: single-port DEPTH x WIDTH line store.
//   clk   in  clock
//   en    in  access enable; read data only updates on an enabled cycle
//   we    in  write enable (qualified by en)
//   addr  in  column address
//   wdata in  write data
//   rdata out registered read data, old contents at addr (read-before-write)
module line_ram #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned DEPTH  = 1600,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: contents are don't-care until written, and stale data is masked upstream.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        mem[addr] <= wdata;
      end
    end
  end

endmodule

// File: rtl/line_window_buffer.sv
// line_window_buffer: keeps the last BUF_DEPTH-1 active lines of a pixel stream in a
// rotating bank of line RAMs and emits, one cycle after each accepted pixel, a vertical
// column of BUF_DEPTH taps (tap 0 = current pixel, tap k = same column k lines above).
//   clk, rst       clock, asynchronous active-high reset
//   frame_start    pulse, restarts column/line bookkeeping (highest priority)
//   data_i, dv_i   input pixel and its valid
//   line_end       pulse, closes the current line (may coincide with the last dv_i)
//   dv_o           output column valid
//   buff_o         taps, tap k at bits [(k+1)*P-1 : k*P]
//   x_o            column index of the current output
//   lines_valid_o  every previous-line tap came from a line of this frame
//   overflow_o     sticky, a pixel arrived past SCREENWIDTH; cleared by frame_start
module line_window_buffer
  import line_buffer_pkg::*;
#(
  parameter int unsigned COLORDEPTH  = DefColorDepth,
  parameter int unsigned CHANNELS    = DefChannels,
  parameter int unsigned SCREENWIDTH = DefScreenWidth,
  parameter int unsigned BUF_DEPTH   = DefBufDepth,
  parameter int unsigned ZERO_FILL   = DefZeroFill,
  parameter int unsigned ADDR_W      = $clog2(SCREENWIDTH + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    frame_start,
  input  logic [CHANNELS*COLORDEPTH-1:0]          data_i,
  input  logic                                    dv_i,
  input  logic                                    line_end,
  output logic                                    dv_o,
  output logic [BUF_DEPTH*CHANNELS*COLORDEPTH-1:0] buff_o,
  output logic [ADDR_W-1:0]                       x_o,
  output logic                                    lines_valid_o,
  output logic                                    overflow_o
);

  localparam int unsigned P       = pix_width(COLORDEPTH, CHANNELS);
  localparam int unsigned NumRams = BUF_DEPTH - 1;
  localparam int unsigned LineW   = (NumRams > 1) ? $clog2(NumRams) : 1;
  localparam int unsigned LsW     = $clog2(BUF_DEPTH);
  localparam int unsigned RamAw   = (SCREENWIDTH > 1) ? $clog2(SCREENWIDTH) : 1;

  logic [ADDR_W-1:0] col_q, col_d, col_eff;
  logic [LineW-1:0]  wr_line_q, wr_line_d, wr_line_eff;
  logic [LsW-1:0]    lines_q, lines_d, lines_eff;
  logic              overflow_q, overflow_d;
  logic              accept;

  logic              dv_q;
  logic [ADDR_W-1:0] x_q;
  logic [P-1:0]      tap0_q;
  logic              lv_q;
  // Per previous-line tap: which RAM feeds it and whether it is zero-filled.
  logic [NumRams-1:0][LineW-1:0] tap_sel_q, tap_sel_d;
  logic [NumRams-1:0]            mask_q, mask_d;

  logic [P-1:0] rd_data [NumRams];

  // frame_start makes this cycle behave as column 0 of line 0 of a fresh frame.
  always_comb begin
    col_eff     = frame_start ? '0 : col_q;
    wr_line_eff = frame_start ? '0 : wr_line_q;
    lines_eff   = frame_start ? '0 : lines_q;
    accept      = dv_i && (col_eff < ADDR_W'(SCREENWIDTH));

    col_d      = col_eff;
    wr_line_d  = wr_line_eff;
    lines_d    = lines_eff;
    overflow_d = frame_start ? 1'b0 : overflow_q;

    if (accept) begin
      col_d = col_eff + ADDR_W'(1);
    end
    if (dv_i && !accept) begin
      overflow_d = 1'b1;
    end
    if (line_end && !frame_start) begin
      col_d = '0;
      // Empty lines do not rotate the RAM bank.
      if ((col_q != '0) || accept) begin
        wr_line_d = (wr_line_q == LineW'(NumRams - 1)) ? '0 : wr_line_q + LineW'(1);
        if (lines_q != LsW'(BUF_DEPTH - 1)) begin
          lines_d = lines_q + LsW'(1);
        end
      end
    end
  end

  for (genvar r = 0; r < NumRams; r++) begin : g_ram
    line_ram #(
      .WIDTH (P),
      .DEPTH (SCREENWIDTH),
      .ADDR_W(RamAw)
    ) u_line_ram (
      .clk  (clk),
      .en   (accept),
      .we   (accept && (wr_line_eff == LineW'(r))),
      .addr (col_eff[RamAw-1:0]),
      .wdata(data_i),
      .rdata(rd_data[r])
    );
  end

  assign buff_o[P-1:0] = tap0_q;

  for (genvar k = 1; k < BUF_DEPTH; k++) begin : g_tap
    assign tap_sel_d[k-1] = LineW'(tap_ram(32'(wr_line_eff), k, NumRams));
    assign mask_d[k-1]    = (ZERO_FILL != 0) && (k > 32'(lines_eff));
    assign buff_o[k*P +: P] = mask_q[k-1] ? '0 : rd_data[tap_sel_q[k-1]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      wr_line_q  <= '0;
      lines_q    <= '0;
      overflow_q <= 1'b0;
      dv_q       <= 1'b0;
      x_q        <= '0;
      tap0_q     <= '0;
      lv_q       <= 1'b0;
      tap_sel_q  <= '0;
      // All-ones mask forces the RAM taps to zero until the first accepted pixel.
      mask_q     <= '1;
    end else begin
      col_q      <= col_d;
      wr_line_q  <= wr_line_d;
      lines_q    <= lines_d;
      overflow_q <= overflow_d;
      dv_q       <= accept;
      if (accept) begin
        x_q       <= col_eff;
        tap0_q    <= data_i;
        lv_q      <= (lines_eff == LsW'(BUF_DEPTH - 1));
        tap_sel_q <= tap_sel_d;
        mask_q    <= mask_d;
      end
    end
  end

  assign dv_o          = dv_q;
  assign x_o           = x_q;
  assign lines_valid_o = lv_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed, table-driven bench for line_window_buffer (SCREENWIDTH=8, BUF_DEPTH=3).
// Each record is one clock of stimulus plus the outputs expected right after that edge.
module tb_line_window_buffer;

  localparam int unsigned CD = 8;
  localparam int unsigned CH = 3;
  localparam int unsigned SW = 8;
  localparam int unsigned BD = 3;
  localparam int unsigned ZF = 1;
  localparam int unsigned P  = CD * CH;
  localparam int unsigned AW = $clog2(SW + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic [P-1:0]  data_i = '0;
  logic          dv_i = 1'b0;
  logic          line_end = 1'b0;
  logic          dv_o;
  logic [BD*P-1:0] buff_o;
  logic [AW-1:0] x_o;
  logic          lines_valid_o;
  logic          overflow_o;

  always #5 clk = ~clk;

  line_window_buffer #(
    .COLORDEPTH (CD),
    .CHANNELS   (CH),
    .SCREENWIDTH(SW),
    .BUF_DEPTH  (BD),
    .ZERO_FILL  (ZF),
    .ADDR_W     (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .data_i       (data_i),
    .dv_i         (dv_i),
    .line_end     (line_end),
    .dv_o         (dv_o),
    .buff_o       (buff_o),
    .x_o          (x_o),
    .lines_valid_o(lines_valid_o),
    .overflow_o   (overflow_o)
  );

  typedef struct {
    logic         fs;
    logic         dv;
    logic         le;
    logic [P-1:0] d;
    logic         edv;
    int           ex;
    logic [P-1:0] et0;
    logic [P-1:0] et1;
    logic [P-1:0] et2;
    logic         elv;
    logic         eovf;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [P-1:0] pix(input int l, input int c);
    return {8'hC3, 8'(l), 8'(c)};
  endfunction

  function automatic void add(input logic fs, input logic dv, input logic le,
                              input logic [P-1:0] d, input logic edv, input int ex,
                              input logic [P-1:0] t1, input logic [P-1:0] t2,
                              input logic elv, input logic eovf);
    vec_t v;
    v.fs = fs; v.dv = dv; v.le = le; v.d = d;
    v.edv = edv; v.ex = ex; v.et0 = d; v.et1 = t1; v.et2 = t2;
    v.elv = elv; v.eovf = eovf;
    vecs.push_back(v);
  endfunction

  function automatic void add_idle(input logic fs, input logic le, input logic eovf);
    add(fs, 1'b0, le, '0, 1'b0, 0, '0, '0, 1'b0, eovf);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    // ---- Build the vector table ----
    add_idle(1'b1, 1'b0, 1'b0);
    // Priming: lines 0..2, line_end with the last pixel.
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 8; c++) begin
        add(1'b0, 1'b1, c == 7, pix(l, c), 1'b1, c,
            (l >= 1) ? pix(l - 1, c) : '0, (l >= 2) ? pix(l - 2, c) : '0, l >= 2, 1'b0);
      end
    end
    // Steady state with gaps; line 3 is closed by a separate line_end.
    for (int l = 3; l < 6; l++) begin
      for (int c = 0; c < 8; c++) begin
        add(1'b0, 1'b1, (l != 3) && (c == 7), pix(l, c), 1'b1, c,
            pix(l - 1, c), pix(l - 2, c), 1'b1, 1'b0);
        if (c % 3 == 1) add_idle(1'b0, 1'b0, 1'b0);
      end
      if (l == 3) add_idle(1'b0, 1'b1, 1'b0);
    end
    // Empty lines must not rotate the bank.
    add_idle(1'b0, 1'b1, 1'b0);
    add_idle(1'b0, 1'b1, 1'b0);
    // Line 6 with a ninth pixel past the end of line.
    for (int c = 0; c < 8; c++) begin
      add(1'b0, 1'b1, 1'b0, pix(6, c), 1'b1, c, pix(5, c), pix(4, c), 1'b1, 1'b0);
    end
    add(1'b0, 1'b1, 1'b0, pix(6, 8), 1'b0, 0, '0, '0, 1'b0, 1'b1);
    add_idle(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      add(1'b0, 1'b1, c == 7, pix(7, c), 1'b1, c, pix(6, c), pix(5, c), 1'b1, 1'b1);
    end
    for (int c = 0; c < 4; c++) begin
      add(1'b0, 1'b1, 1'b0, pix(8, c), 1'b1, c, pix(7, c), pix(6, c), 1'b1, 1'b1);
    end
    // frame_start with a pixel and a line_end mid-line: restart at column 0.
    add(1'b1, 1'b1, 1'b1, pix(8, 4), 1'b1, 0, '0, '0, 1'b0, 1'b0);
    for (int c = 5; c < 8; c++) begin
      add(1'b0, 1'b1, c == 7, pix(8, c), 1'b1, c - 4, '0, '0, 1'b0, 1'b0);
    end
    // Second line of the new frame: tap 1 is the restarted line, tap 2 still zero-filled.
    for (int c = 0; c < 4; c++) begin
      add(1'b0, 1'b1, 1'b0, pix(9, c), 1'b1, c, pix(8, c + 4), '0, 1'b0, 1'b0);
    end

    // ---- Reset state ----
    #1 rst = 1'b1;
    #2;
    chk("reset dv_o", 32'(dv_o), 32'(0));
    chk("reset x_o", 32'(x_o), 32'(0));
    chk("reset tap0", 32'(buff_o[P-1:0]), 32'(0));
    chk("reset tap1", 32'(buff_o[2*P-1:P]), 32'(0));
    chk("reset tap2", 32'(buff_o[3*P-1:2*P]), 32'(0));
    chk("reset lines_valid_o", 32'(lines_valid_o), 32'(0));
    chk("reset overflow_o", 32'(overflow_o), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // ---- Table ----
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      frame_start = vecs[i].fs;
      dv_i        = vecs[i].dv;
      line_end    = vecs[i].le;
      data_i      = vecs[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d dv_o", i), 32'(dv_o), 32'(vecs[i].edv));
      chk($sformatf("v%0d overflow_o", i), 32'(overflow_o), 32'(vecs[i].eovf));
      if (vecs[i].edv) begin
        chk($sformatf("v%0d x_o", i), 32'(x_o), 32'(vecs[i].ex));
        chk($sformatf("v%0d tap0", i), 32'(buff_o[P-1:0]), 32'(vecs[i].et0));
        chk($sformatf("v%0d tap1", i), 32'(buff_o[2*P-1:P]), 32'(vecs[i].et1));
        chk($sformatf("v%0d tap2", i), 32'(buff_o[3*P-1:2*P]), 32'(vecs[i].et2));
        chk($sformatf("v%0d lines_valid_o", i), 32'(lines_valid_o), 32'(vecs[i].elv));
      end
    end

    // ---- Asynchronous reset mid-line ----
    @(negedge clk);
    frame_start = 1'b0;
    line_end    = 1'b0;
    dv_i        = 1'b1;
    data_i      = pix(9, 4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset dv_o", 32'(dv_o), 32'(0));
    chk("midreset x_o", 32'(x_o), 32'(0));
    chk("midreset tap0", 32'(buff_o[P-1:0]), 32'(0));
    chk("midreset tap1", 32'(buff_o[2*P-1:P]), 32'(0));
    chk("midreset lines_valid_o", 32'(lines_valid_o), 32'(0));
    @(negedge clk);
    rst    = 1'b0;
    dv_i   = 1'b1;
    data_i = pix(20, 0);
    @(posedge clk);
    #1;
    chk("post-reset dv_o", 32'(dv_o), 32'(1));
    chk("post-reset x_o", 32'(x_o), 32'(0));
    chk("post-reset tap0", 32'(buff_o[P-1:0]), 32'(pix(20, 0)));
    chk("post-reset tap1", 32'(buff_o[2*P-1:P]), 32'(0));
    chk("post-reset tap2", 32'(buff_o[3*P-1:2*P]), 32'(0));
    chk("post-reset lines_valid_o", 32'(lines_valid_o), 32'(0));
    @(negedge clk);
    dv_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
